// File: rtl/dnoc_dma_wr_ring.sv
// rtl/dnoc_dma_wr_ring.sv - DMA write channel: NoC data into an N-deep ring of L2 buffers via a loop address generator
//
// Core jobs issue one NoC read-out request per buffer fill and step through
// the buffer ring, waiting on consumer back-pressure between fills.
// NoC jobs take pushed data into a single region and then send a write
// response back to the requesting node.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   c_cfg_*, c_req / c_gnt       core job configuration and handshake
//   n_cfg_*, n_req / n_gnt       NoC job configuration and handshake
//   buf_busy                     per-buffer "still held by consumer"
//   buf_wr_done, buf_wr_idx      fill-complete pulse and buffer index
//   in_data/in_valid/in_ready    incoming NoC data beats
//   out_req/out_gnt, out_addr,
//   out_len, out_mode,
//   out_resp_sel                 outgoing NoC request (read-out or response)
//   ram_wr_en/addr/data          L2 write port
//   xfer_done, busy              job-complete pulse, channel active
module dnoc_dma_wr_ring #(
  parameter int DW    = 256,
  parameter int AW    = 13,
  parameter int NA    = 25,
  parameter int NBUF  = 2,
  parameter int NLOOP = 4,
  parameter int CW    = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NBUF*AW-1:0]    c_cfg_base_addr,
  input  logic [NBUF*AW-1:0]    c_cfg_buf_len,
  input  logic                  c_cfg_ring_en,
  input  logic [CW-1:0]         c_cfg_ring_num,
  input  logic [NA-1:0]         c_cfg_noc_base_addr,
  input  logic [NLOOP*AW-1:0]   c_cfg_loop_len,
  input  logic [NLOOP*AW-1:0]   c_cfg_loop_gap,
  input  logic                  c_req,
  output logic                  c_gnt,
  input  logic [AW-1:0]         n_cfg_ram_base_addr,
  input  logic [AW-1:0]         n_cfg_len,
  input  logic [3:0]            n_cfg_source_id,
  input  logic                  n_cfg_resp_sel,
  input  logic [NLOOP*AW-1:0]   n_cfg_loop_len,
  input  logic [NLOOP*AW-1:0]   n_cfg_loop_gap,
  input  logic                  n_req,
  output logic                  n_gnt,
  input  logic [NBUF-1:0]       buf_busy,
  output logic                  buf_wr_done,
  output logic [1:0]            buf_wr_idx,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_req,
  input  logic                  out_gnt,
  output logic [NA-1:0]         out_addr,
  output logic [AW-1:0]         out_len,
  output logic                  out_mode,
  output logic                  out_resp_sel,
  output logic                  ram_wr_en,
  output logic [AW-1:0]         ram_wr_addr,
  output logic [DW-1:0]         ram_wr_data,
  output logic                  xfer_done,
  output logic                  busy
);

  localparam int IW = (NBUF > 1) ? $clog2(NBUF) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_WR     = 3'd2,
    S_CHECK  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched job configuration
  logic                job_core_q;
  logic                ring_en_q;
  logic [CW-1:0]       fills_q;
  logic [CW-1:0]       fill_cnt_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       wr_idx_q;
  logic [AW-1:0]       base_q [NBUF];
  logic [AW-1:0]       len_q [NBUF];
  logic [AW-1:0]       n_len_q;
  logic [AW-1:0]       loop_len_q [NLOOP];
  logic [AW-1:0]       loop_gap_q [NLOOP];
  logic [NA-1:0]       out_addr_q;
  logic                out_mode_q;
  logic                resp_sel_q;

  // Beat counter within the current fill and the address generator
  logic [AW-1:0]       beat_cnt_q;
  logic [AW-1:0]       gen_addr_q;
  logic [AW-1:0]       gen_cnt_q [NLOOP];
  logic [AW-1:0]       gen_cnt_d [NLOOP];
  logic [AW-1:0]       gap_sel;

  logic [AW-1:0]       cur_len;
  logic                beat;
  logic                last_beat;
  logic                fill_end;
  logic                all_filled;
  logic [CW-1:0]       c_fills;

  assign cur_len    = job_core_q ? len_q[idx_q] : n_len_q;
  assign beat       = (state_q == S_WR) && in_valid;
  assign last_beat  = (beat_cnt_q == cur_len - AW'(1));
  assign all_filled = (fill_cnt_q == fills_q);
  // A ring count of 0 would never match the fill counter, so run it as one fill.
  assign c_fills    = !c_cfg_ring_en ? CW'(1) :
                      (c_cfg_ring_num == '0) ? CW'(1) : c_cfg_ring_num;
  // A core fill ends on its last beat, or at the grant when its length is 0.
  assign fill_end   = job_core_q &&
                      ((beat && last_beat) ||
                       ((state_q == S_RD_REQ) && out_gnt && (cur_len == '0)));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (c_req) begin
          state_d = S_RD_REQ;
        end else if (n_req) begin
          state_d = (n_cfg_len == '0) ? S_RESP : S_WR;
        end
      end
      S_RD_REQ: begin
        if (out_gnt) begin
          state_d = (cur_len == '0) ? S_CHECK : S_WR;
        end
      end
      S_WR: begin
        if (beat && last_beat) begin
          state_d = job_core_q ? S_CHECK : S_RESP;
        end
      end
      S_CHECK: begin
        if (all_filled) begin
          state_d = S_IDLE;
        end else if (!buf_busy[idx_q]) begin
          state_d = S_RD_REQ;
        end
      end
      S_RESP: begin
        if (out_gnt) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    c_gnt       = 1'b0;
    n_gnt       = 1'b0;
    out_req     = 1'b0;
    in_ready    = 1'b0;
    ram_wr_en   = 1'b0;
    buf_wr_done = 1'b0;
    xfer_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        c_gnt = c_req;
        n_gnt = n_req && !c_req;
      end
      S_RD_REQ: out_req = 1'b1;
      S_WR: begin
        in_ready    = in_valid;
        ram_wr_en   = in_valid;
        buf_wr_done = beat && last_beat && job_core_q && ring_en_q;
      end
      S_CHECK: xfer_done = all_filled;
      S_RESP: begin
        out_req   = 1'b1;
        xfer_done = out_gnt;
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign out_addr     = out_addr_q;
  assign out_len      = cur_len;
  assign out_mode     = out_mode_q;
  assign out_resp_sel = resp_sel_q;
  assign buf_wr_idx   = 2'(wr_idx_q);
  assign ram_wr_addr  = gen_addr_q;
  // Data is gated so the write port reads all-zero whenever no write happens.
  assign ram_wr_data  = ram_wr_en ? in_data : '0;

  // ---------------------------------------------------------------- job control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_core_q <= 1'b0;
      ring_en_q  <= 1'b0;
      fills_q    <= '0;
      fill_cnt_q <= '0;
      idx_q      <= '0;
      wr_idx_q   <= '0;
      n_len_q    <= '0;
      out_addr_q <= '0;
      out_mode_q <= 1'b0;
      resp_sel_q <= 1'b0;
      beat_cnt_q <= '0;
      for (int i = 0; i < NBUF; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
      end
      for (int i = 0; i < NLOOP; i++) begin
        loop_len_q[i] <= '0;
        loop_gap_q[i] <= '0;
      end
    end else begin
      if (c_gnt) begin
        job_core_q <= 1'b1;
        ring_en_q  <= c_cfg_ring_en;
        fills_q    <= c_fills;
        fill_cnt_q <= '0;
        idx_q      <= '0;
        out_addr_q <= c_cfg_noc_base_addr;
        out_mode_q <= 1'b0;
        resp_sel_q <= 1'b0;
        for (int i = 0; i < NBUF; i++) begin
          base_q[i] <= c_cfg_base_addr[i*AW +: AW];
          len_q[i]  <= c_cfg_buf_len[i*AW +: AW];
        end
        for (int i = 0; i < NLOOP; i++) begin
          loop_len_q[i] <= c_cfg_loop_len[i*AW +: AW];
          loop_gap_q[i] <= c_cfg_loop_gap[i*AW +: AW];
        end
      end else if (n_gnt) begin
        job_core_q <= 1'b0;
        ring_en_q  <= 1'b0;
        fills_q    <= CW'(1);
        fill_cnt_q <= '0;
        idx_q      <= '0;
        n_len_q    <= n_cfg_len;
        out_addr_q <= NA'({n_cfg_source_id, 13'b0});
        out_mode_q <= 1'b1;
        resp_sel_q <= n_cfg_resp_sel;
        beat_cnt_q <= '0;
        for (int i = 0; i < NLOOP; i++) begin
          loop_len_q[i] <= n_cfg_loop_len[i*AW +: AW];
          loop_gap_q[i] <= n_cfg_loop_gap[i*AW +: AW];
        end
      end

      if (state_q == S_RD_REQ) begin
        wr_idx_q   <= idx_q;
        beat_cnt_q <= '0;
      end else if (beat) begin
        beat_cnt_q <= beat_cnt_q + AW'(1);
      end

      if (fill_end) begin
        out_addr_q <= out_addr_q + NA'(cur_len);
        idx_q      <= (idx_q == IW'(NBUF - 1)) ? '0 : idx_q + IW'(1);
        fill_cnt_q <= fill_cnt_q + CW'(1);
      end else if ((state_q == S_CHECK) && all_filled) begin
        fill_cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- address generator
  // Odometer step: the lowest level that has not reached its end increments,
  // every level below it clears, and its gap is added. When every level wraps,
  // the whole nest restarts and the outermost gap is applied.
  always_comb begin
    logic carry;
    logic [AW-1:0] eff_len;
    carry   = 1'b1;
    gap_sel = loop_gap_q[NLOOP-1];
    for (int i = 0; i < NLOOP; i++) begin
      gen_cnt_d[i] = gen_cnt_q[i];
      eff_len      = (loop_len_q[i] == '0) ? AW'(1) : loop_len_q[i];
      if (carry) begin
        if (gen_cnt_q[i] == eff_len - AW'(1)) begin
          gen_cnt_d[i] = '0;
        end else begin
          gen_cnt_d[i] = gen_cnt_q[i] + AW'(1);
          gap_sel      = loop_gap_q[i];
          carry        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_addr_q <= '0;
      for (int i = 0; i < NLOOP; i++) begin
        gen_cnt_q[i] <= '0;
      end
    end else if (n_gnt) begin
      gen_addr_q <= n_cfg_ram_base_addr;
      for (int i = 0; i < NLOOP; i++) begin
        gen_cnt_q[i] <= '0;
      end
    end else if (state_q == S_RD_REQ) begin
      gen_addr_q <= base_q[idx_q];
      for (int i = 0; i < NLOOP; i++) begin
        gen_cnt_q[i] <= '0;
      end
    end else if (beat) begin
      gen_addr_q <= gen_addr_q + gap_sel;
      for (int i = 0; i < NLOOP; i++) begin
        gen_cnt_q[i] <= gen_cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dnoc_dma_wr_ring.sv
// tb/tb_dnoc_dma_wr_ring.sv - directed self-checking bench for dnoc_dma_wr_ring
module tb_dnoc_dma_wr_ring;

  localparam int DW = 256, AW = 13, NA = 25, NBUF = 2, NLOOP = 4, CW = 11;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NBUF*AW-1:0]  c_cfg_base_addr, c_cfg_buf_len;
  logic                c_cfg_ring_en;
  logic [CW-1:0]       c_cfg_ring_num;
  logic [NA-1:0]       c_cfg_noc_base_addr;
  logic [NLOOP*AW-1:0] c_cfg_loop_len, c_cfg_loop_gap;
  logic                c_req, c_gnt;
  logic [AW-1:0]       n_cfg_ram_base_addr, n_cfg_len;
  logic [3:0]          n_cfg_source_id;
  logic                n_cfg_resp_sel;
  logic [NLOOP*AW-1:0] n_cfg_loop_len, n_cfg_loop_gap;
  logic                n_req, n_gnt;
  logic [NBUF-1:0]     buf_busy;
  logic                buf_wr_done;
  logic [1:0]          buf_wr_idx;
  logic [DW-1:0]       in_data;
  logic                in_valid, in_ready;
  logic                out_req, out_gnt;
  logic [NA-1:0]       out_addr;
  logic [AW-1:0]       out_len;
  logic                out_mode, out_resp_sel;
  logic                ram_wr_en;
  logic [AW-1:0]       ram_wr_addr;
  logic [DW-1:0]       ram_wr_data;
  logic                xfer_done, busy;

  dnoc_dma_wr_ring #(.DW(DW), .AW(AW), .NA(NA), .NBUF(NBUF), .NLOOP(NLOOP), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_cfg_base_addr(c_cfg_base_addr), .c_cfg_buf_len(c_cfg_buf_len),
    .c_cfg_ring_en(c_cfg_ring_en), .c_cfg_ring_num(c_cfg_ring_num),
    .c_cfg_noc_base_addr(c_cfg_noc_base_addr),
    .c_cfg_loop_len(c_cfg_loop_len), .c_cfg_loop_gap(c_cfg_loop_gap),
    .c_req(c_req), .c_gnt(c_gnt),
    .n_cfg_ram_base_addr(n_cfg_ram_base_addr), .n_cfg_len(n_cfg_len),
    .n_cfg_source_id(n_cfg_source_id), .n_cfg_resp_sel(n_cfg_resp_sel),
    .n_cfg_loop_len(n_cfg_loop_len), .n_cfg_loop_gap(n_cfg_loop_gap),
    .n_req(n_req), .n_gnt(n_gnt),
    .buf_busy(buf_busy), .buf_wr_done(buf_wr_done), .buf_wr_idx(buf_wr_idx),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_req(out_req), .out_gnt(out_gnt), .out_addr(out_addr), .out_len(out_len),
    .out_mode(out_mode), .out_resp_sel(out_resp_sel),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .xfer_done(xfer_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Stimulus controls and scoreboard
  int   cyc = 0;
  logic feed_en = 1'b0;
  logic gap_mode = 1'b0;
  logic auto_gnt = 1'b1;

  logic [AW-1:0] wa_q[$];
  int            wc_q[$];
  logic [31:0]   wd_q[$];
  logic [NA-1:0] ra_q[$];
  logic          rm_q[$];
  logic          rs_q[$];
  int            rc_q[$];
  logic [1:0]    bidx_q[$];
  int            bwd_cyc_q[$];
  int xfer_cnt = 0, bwd_cnt = 0, oreq_cnt = 0, ngnt_cnt = 0;
  int xdone_cyc = 0, ngnt_cyc = 0;

  // Responder and data source: act just after each rising edge
  initial begin
    out_gnt  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      out_gnt  = out_req & auto_gnt;
      in_valid = feed_en & (gap_mode ? cyc[0] : 1'b1);
      in_data  = DW'(cyc);
    end
  end

  // Monitor: sample away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (ram_wr_en) begin
        wa_q.push_back(ram_wr_addr);
        wc_q.push_back(cyc);
        wd_q.push_back(ram_wr_data[31:0]);
      end
      if (xfer_done) begin xfer_cnt++; xdone_cyc = cyc; end
      if (buf_wr_done) begin bwd_cnt++; bidx_q.push_back(buf_wr_idx); bwd_cyc_q.push_back(cyc); end
      if (out_req) oreq_cnt++;
      if (out_req && out_gnt) begin
        ra_q.push_back(out_addr); rm_q.push_back(out_mode);
        rs_q.push_back(out_resp_sel); rc_q.push_back(cyc);
      end
      if (n_gnt) begin ngnt_cnt++; ngnt_cyc = cyc; end
    end
  end

  task automatic clear_sb();
    wa_q.delete(); wc_q.delete(); wd_q.delete();
    ra_q.delete(); rm_q.delete(); rs_q.delete(); rc_q.delete();
    bidx_q.delete(); bwd_cyc_q.delete();
    xfer_cnt = 0; bwd_cnt = 0; oreq_cnt = 0; ngnt_cnt = 0;
  endtask

  task automatic start_core();
    @(posedge clk); #1;
    c_req = 1'b1; #1;
    check_eq("c_gnt", c_gnt, 1);
    @(posedge clk); #1;
    c_req = 1'b0;
  endtask

  task automatic start_noc();
    @(posedge clk); #1;
    n_req = 1'b1; #1;
    check_eq("n_gnt", n_gnt, 1);
    @(posedge clk); #1;
    n_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    int start;
    n = 0;
    start = xfer_cnt;
    while (xfer_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (xfer_cnt == start) check_eq({tag, "_timeout"}, 0, 1);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int xd1;
    rst_n = 1'b0;
    c_req = 1'b0; n_req = 1'b0; buf_busy = '0;
    c_cfg_base_addr     = {13'h200, 13'h000};
    c_cfg_buf_len       = {13'd8, 13'd8};
    c_cfg_ring_en       = 1'b1;
    c_cfg_ring_num      = 11'd4;
    c_cfg_noc_base_addr = 25'h1000;
    c_cfg_loop_len      = {13'd0, 13'd0, 13'd0, 13'd8};
    c_cfg_loop_gap      = {13'd0, 13'd0, 13'd0, 13'd1};
    n_cfg_ram_base_addr = 13'h100;
    n_cfg_len           = 13'd4;
    n_cfg_source_id     = 4'd5;
    n_cfg_resp_sel      = 1'b1;
    n_cfg_loop_len      = {13'd0, 13'd0, 13'd0, 13'd4};
    n_cfg_loop_gap      = {13'd0, 13'd0, 13'd0, 13'd1};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_req", out_req, 0);
    check_eq("rst_out_addr", out_addr, 0);
    check_eq("rst_out_len", out_len, 0);
    check_eq("rst_ram_wr_en", ram_wr_en, 0);
    check_eq("rst_buf_wr_idx", buf_wr_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // NoC job, 4 back-to-back beats
    clear_sb();
    feed_en = 1'b1;
    start_noc();
    wait_done("noc", 100);
    check_eq("noc_wr_count", wa_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check_eq("noc_wr_addr", (i < wa_q.size()) ? 64'(wa_q[i]) : 64'hBAD, 64'h100 + 64'(i));
    if (wa_q.size() == 4) begin
      check_eq("noc_wr_consec", wc_q[3] - wc_q[0], 3);
      check_eq("noc_wr_data", wd_q[0], wc_q[0]);
    end
    check_eq("noc_resp_cnt", ra_q.size(), 1);
    if (ra_q.size() == 1) begin
      check_eq("noc_resp_addr", ra_q[0], 25'h0A000);
      check_eq("noc_resp_mode", rm_q[0], 1);
      check_eq("noc_resp_sel", rs_q[0], 1);
    end
    check_eq("noc_xfer_done", xfer_cnt, 1);

    // Core ring job, 4 fills over 2 buffers
    clear_sb();
    start_core();
    wait_done("ring", 500);
    check_eq("ring_req_cnt", ra_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("ring_req_addr", (i < ra_q.size()) ? 64'(ra_q[i]) : 64'hBAD, 64'h1000 + 64'(8 * i));
      check_eq("ring_req_mode", (i < rm_q.size()) ? 64'(rm_q[i]) : 64'hBAD, 0);
      check_eq("ring_idx", (i < bidx_q.size()) ? 64'(bidx_q[i]) : 64'hBAD, 64'(i % 2));
    end
    check_eq("ring_bwd_cnt", bwd_cnt, 4);
    check_eq("ring_xfer_cnt", xfer_cnt, 1);
    check_eq("ring_wr_cnt", wa_q.size(), 32);
    if (wa_q.size() == 32) begin
      check_eq("ring_wr_b1_first", wa_q[8], 13'h200);
      check_eq("ring_wr_last", wa_q[31], 13'h207);
    end

    // Same job with buffer 1 held by the consumer for 10 cycles
    clear_sb();
    buf_busy = 2'b10;
    start_core();
    n = 0;
    while (bwd_cnt == 0 && n < 200) begin @(posedge clk); n++; end
    check_eq("stall_first_fill", bwd_cnt, 1);
    repeat (10) @(posedge clk);
    #1 buf_busy = 2'b00;
    wait_done("stall", 500);
    check_eq("stall_oreq_cycles", oreq_cnt, 4);
    if (rc_q.size() > 1 && bwd_cyc_q.size() > 0)
      check_eq("stall_gap", rc_q[1] - bwd_cyc_q[0], 12);
    else
      check_eq("stall_gap_missing", 0, 1);
    check_eq("stall_xfer_cnt", xfer_cnt, 1);

    // Simultaneous requests: core first, NoC granted after core completion
    clear_sb();
    c_cfg_ring_en       = 1'b0;
    n_cfg_ram_base_addr = 13'h050;
    n_cfg_len           = 13'd2;
    n_cfg_source_id     = 4'd3;
    n_cfg_resp_sel      = 1'b0;
    @(posedge clk); #1;
    c_req = 1'b1; n_req = 1'b1; #1;
    check_eq("prio_c_gnt", c_gnt, 1);
    check_eq("prio_n_gnt", n_gnt, 0);
    @(posedge clk); #1;
    c_req = 1'b0;
    wait_done("prio_core", 200);
    xd1 = xdone_cyc;
    #1 n_req = 1'b0;
    wait_done("prio_noc", 200);
    check_eq("prio_ngnt_cnt", ngnt_cnt, 1);
    check_eq("prio_ngnt_after", ngnt_cyc - xd1, 1);
    check_eq("prio_bwd_none", bwd_cnt, 0);
    check_eq("prio_req_cnt", ra_q.size(), 2);
    if (ra_q.size() == 2) begin
      check_eq("prio_core_addr", ra_q[0], 25'h1000);
      check_eq("prio_noc_addr", ra_q[1], 25'h06000);
      check_eq("prio_noc_sel", rs_q[1], 0);
    end
    check_eq("prio_wr_cnt", wa_q.size(), 10);

    // 2-D loop with input gaps
    clear_sb();
    gap_mode            = 1'b1;
    n_cfg_ram_base_addr = 13'h000;
    n_cfg_len           = 13'd6;
    n_cfg_loop_len      = {13'd0, 13'd0, 13'd2, 13'd3};
    n_cfg_loop_gap      = {13'd0, 13'd0, 13'h10, 13'd1};
    start_noc();
    wait_done("loop2d", 200);
    check_eq("loop2d_wr_cnt", wa_q.size(), 6);
    begin
      logic [AW-1:0] exp_addr [6];
      exp_addr = '{13'h0, 13'h1, 13'h2, 13'h12, 13'h13, 13'h14};
      for (int i = 0; i < 6; i++)
        check_eq("loop2d_addr", (i < wa_q.size()) ? 64'(wa_q[i]) : 64'hBAD, 64'(exp_addr[i]));
    end
    gap_mode = 1'b0;

    // Zero-length NoC job
    clear_sb();
    n_cfg_len = 13'd0;
    start_noc();
    wait_done("zero", 50);
    check_eq("zero_no_wr", wa_q.size(), 0);
    check_eq("zero_resp_cnt", rc_q.size(), 1);
    if (rc_q.size() == 1) check_eq("zero_resp_next", rc_q[0] - ngnt_cyc, 1);

    // Reset in the middle of WR
    clear_sb();
    n_cfg_len = 13'd8;
    start_noc();
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_ram_wr_en", ram_wr_en, 0);
    check_eq("mid_rst_ram_addr", ram_wr_addr, 0);
    check_eq("mid_rst_out_addr", out_addr, 0);
    check_eq("mid_rst_out_mode", out_mode, 0);
    check_eq("mid_rst_xfer", xfer_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check_eq("mid_rst_no_done", xfer_cnt, 0);
    check_eq("mid_rst_no_resp", ra_q.size(), 0);
    feed_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
